// File: rtl/inst_prefetch.sv
// Instruction prefetch: sequential word fetch over a req/gnt bus, FIFO of returned words, redirect flush.
// Define INST_PREFETCH_MISALIGN_EN to add o_misaligned and halt on misaligned redirect targets.
module inst_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
`ifdef INST_PREFETCH_MISALIGN_EN
  output logic        o_misaligned,
`endif
  input  logic        i_inst_ready
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {StIdle, StRun, StFlush, StHalt} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fpc_q, fpc_d;
  logic [31:0]   head_pc_q, head_pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] disc_q, disc_d;
  logic [31:0]   inst_q, inst_d;
  logic [31:0]   inst_pc_q, inst_pc_d;
  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];
  logic          misaligned_q, misaligned_d;

  logic [CW-1:0] used;
  logic [31:0]   redir_pc;
  logic          halted, grant, accept, push, pop;

  always_comb begin
    redir_pc     = i_redirect_pc & 32'hFFFF_FFFC;
    halted       = (state_q == StHalt);
    used         = count_q + out_q + disc_q;
    o_mem_req    = (state_q != StIdle) && !halted && (used < CW'(DEPTH)) && !i_redirect;
    o_mem_addr   = fpc_q;
    o_inst_valid = (count_q != '0) && !halted;
    o_inst       = inst_q;
    o_inst_pc    = inst_pc_q;
    grant        = o_mem_req && i_mem_gnt;
    accept       = i_mem_rvalid && (disc_q == '0);
    push         = accept && !i_redirect;
    pop          = o_inst_valid && i_inst_ready && !i_redirect;
  end

  always_comb begin
    fpc_d     = fpc_q;
    head_pc_d = head_pc_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    out_d     = out_q;
    disc_d    = disc_q;
    mem_d     = mem_q;
    if (i_redirect) begin
      fpc_d     = redir_pc;
      head_pc_d = redir_pc;
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      count_d   = '0;
      out_d     = '0;
      // Everything still in flight becomes stale; a same-cycle response is one of them.
      disc_d    = out_q + disc_q - CW'(i_mem_rvalid);
    end else begin
      if (grant) fpc_d = fpc_q + 32'd4;
      out_d = out_q + CW'(grant) - CW'(accept);
      if (i_mem_rvalid && (disc_q != '0)) disc_d = disc_q - CW'(1);
      if (push) begin
        mem_d[wr_ptr_q] = i_mem_rdata;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d  = rd_ptr_q + PW'(1);
        head_pc_d = head_pc_q + 32'd4;
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Head registers track the entry that will be at the FIFO head next cycle; held when empty.
  always_comb begin
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    if (count_d != '0) begin
      inst_pc_d = head_pc_d;
      if ((count_q - CW'(pop)) == '0) inst_d = i_mem_rdata;
      else                            inst_d = mem_q[rd_ptr_d];
    end
  end

  always_comb begin
    state_d      = state_q;
    misaligned_d = misaligned_q;
    case (state_q)
      StIdle:  state_d = StRun;
      StRun:   if (i_redirect && (disc_d != '0)) state_d = StFlush;
      StFlush: if (!i_redirect && (disc_d == '0)) state_d = StRun;
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
`ifdef INST_PREFETCH_MISALIGN_EN
    if (i_redirect) begin
      if (i_redirect_pc[1:0] != 2'b00) begin
        state_d      = StHalt;
        misaligned_d = 1'b1;
      end else if (halted) begin
        state_d      = (disc_d != '0) ? StFlush : StRun;
        misaligned_d = 1'b0;
      end
    end
`endif
  end

`ifdef INST_PREFETCH_MISALIGN_EN
  assign o_misaligned = misaligned_q;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= StIdle;
      fpc_q        <= RESET_PC;
      head_pc_q    <= RESET_PC;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      out_q        <= '0;
      disc_q       <= '0;
      inst_q       <= '0;
      inst_pc_q    <= RESET_PC;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fpc_q        <= fpc_d;
      head_pc_q    <= head_pc_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      out_q        <= out_d;
      disc_q       <= disc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      misaligned_q <= misaligned_d;
    end
  end

  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

endmodule
